serial_pixel_capture: RTL

Synthesizable capture engine for the serial pixel stream produced by the sobel/pooling pipeline. It controls serial_ready and deserializes LANES bits per accepted beat, MSB-first, into PIX_W-bit pixels. Each pixel is stored in an internal frame buffer of PIXEL_CNT entries. It also reports frame completion or timeout and provides a registered readback port, which makes in-system frame checks possible.

---
 rtl/serial_pixel_capture.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_pixel_capture.sv
// Serial pixel capture: throttles serial_ready, deserializes LANES bits per beat
// MSB-first into PIX_W-bit pixels, stores a frame and offers registered readback.
module serial_pixel_capture #(
   parameter int          PIX_W        = 8,
   parameter int          LANES        = 1,
   parameter int          PIXEL_CNT    = 961,
   parameter int          READY_MODE   = 2,
   parameter int          READY_THRESH = 102,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          TIMEOUT_CYC  = 65535,
   localparam int         CNT_W        = $clog2(PIXEL_CNT + 1),
   localparam int         ADDR_W       = $clog2(PIXEL_CNT)
) (
   input  logic              clk_200mhz,
   input  logic              reset,
   input  logic              start,
   input  logic [LANES-1:0]  serial_data,
   input  logic              serial_valid,
   output logic              serial_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              timeout,
   output logic              extra_data,
   output logic [CNT_W-1:0]  pixel_count,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data
);

   localparam int BPP    = PIX_W / LANES;
   localparam int BEAT_W = (BPP > 1) ? $clog2(BPP) : 1;
   localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPP - 1);
   localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(PIXEL_CNT - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [ADDR_W:0]   RD_LIMIT  = (ADDR_W + 1)'(PIXEL_CNT);
   localparam logic [7:0]        THRESH8   = 8'(READY_THRESH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]        state;
   logic [BEAT_W-1:0] beat;
   logic [IDLE_W-1:0] idle_cnt;
   logic [15:0]       lfsr;
   logic [PIX_W-1:0]  pix_next;
   logic [PIX_W-1:0]  mem [PIXEL_CNT];

   logic accept, last_beat, last_pix, to_hit, ready_next;

   // serial_ready is only ever high in CAPTURE, so a handshake implies CAPTURE
   assign accept    = serial_valid && serial_ready;
   assign last_beat = accept && (beat == BEAT_LAST);
   assign last_pix  = last_beat && (pixel_count == PIX_LAST);
   assign to_hit    = (TIMEOUT_CYC != 0) && (state == CAPTURE) && !accept && (idle_cnt == IDLE_LAST);
   assign busy      = (state == CAPTURE);

   generate
      if (BPP == 1) begin : g_one
         assign pix_next = serial_data;
      end else begin : g_shift
         logic [PIX_W-LANES-1:0] sh;
         assign pix_next = {sh, serial_data};
         always_ff @(posedge clk_200mhz) begin
            if (reset)       sh <= '0;
            else if (accept) sh <= pix_next[PIX_W-LANES-1:0];
         end
      end
   endgenerate

   always_comb begin
      ready_next = 1'b1;
      if (READY_MODE == 1) begin
         ready_next = !accept;
      end else if (READY_MODE == 2) begin
         if (accept)             ready_next = 1'b0;
         else if (!serial_ready) ready_next = (lfsr[7:0] >= THRESH8);
      end
   end

   always_ff @(posedge clk_200mhz) begin
      if (reset) begin
         state        <= IDLE;
         serial_ready <= 1'b0;
         frame_done   <= 1'b0;
         timeout      <= 1'b0;
         extra_data   <= 1'b0;
         pixel_count  <= '0;
         beat         <= '0;
         idle_cnt     <= '0;
         lfsr         <= LFSR_SEED;
      end else begin
         frame_done <= 1'b0;
         case (state)
            CAPTURE: begin
               lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
               if (accept) begin
                  idle_cnt <= '0;
                  if (last_beat) begin
                     beat        <= '0;
                     pixel_count <= pixel_count + 1'b1;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end else if (TIMEOUT_CYC != 0) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
               if (last_pix || to_hit) begin
                  state        <= DONE;
                  frame_done   <= 1'b1;
                  serial_ready <= 1'b0;
                  timeout      <= to_hit;
               end else begin
                  serial_ready <= ready_next;
               end
            end
            default: begin
               // IDLE and DONE: ready stays low; ready can first rise one cycle after CAPTURE entry
               serial_ready <= 1'b0;
               if (state == DONE && serial_valid) extra_data <= 1'b1;
               if (start) begin
                  state       <= CAPTURE;
                  pixel_count <= '0;
                  beat        <= '0;
                  timeout     <= 1'b0;
                  extra_data  <= 1'b0;
                  idle_cnt    <= '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_200mhz) begin
      if (last_beat && !reset) mem[pixel_count[ADDR_W-1:0]] <= pix_next;
   end

   // read-first: a same-cycle write to rd_addr is seen one read later
   always_ff @(posedge clk_200mhz) begin
      if (reset)                           rd_data <= '0;
      else if ({1'b0, rd_addr} < RD_LIMIT) rd_data <= mem[rd_addr];
      else                                 rd_data <= '0;
   end

endmodule
